// File: rtl/simplebus_mem_responder.sv
// simplebus_mem_responder
//   SimpleBus responder (slave end) built around a word-addressed 64-bit memory.
//   It serves single reads, critical-word-first wrapping read bursts, byte-masked
//   single writes, multi-beat write bursts, probes (always a miss) and prefetches
//   (dropped). It also works as a synthesizable scratch RAM.
//
// Ports
//   i_clock          single clock, all logic on posedge
//   i_reset          asynchronous, active-high
//   o_req_ready      responder can accept a request beat
//   i_req_valid      request beat valid
//   i_req_addr       byte address; word index = addr[DEPTH_LOG2+2:3]
//   i_req_size       ignored, accesses are always 64-bit
//   i_req_cmd        command encoding (see localparams)
//   i_req_wmask      byte enables for writes
//   i_req_wdata      write data
//   i_req_user       opaque tag, echoed on the response
//   i_resp_ready     initiator accepts response beat
//   o_resp_valid     response beat valid
//   o_resp_cmd       response command
//   o_resp_rdata     read data
//   o_resp_user      echoed tag of the owning request
//
// state      | meaning
// -----------+-------------------------------------------------------------
// S_IDLE     | ready for any request
// S_RESP     | single response beat pending, requests blocked
// S_RD_BURST | streaming BURST_LEN read beats, requests blocked
// S_WR_BURST | collecting write-burst beats until WRITE_LAST

module simplebus_mem_responder #(
  parameter int DEPTH_LOG2 = 10,
  parameter int BURST_LEN  = 4
) (
  input  logic        i_clock,
  input  logic        i_reset,
  output logic        o_req_ready,
  input  logic        i_req_valid,
  input  logic [31:0] i_req_addr,
  input  logic [2:0]  i_req_size,
  input  logic [3:0]  i_req_cmd,
  input  logic [7:0]  i_req_wmask,
  input  logic [63:0] i_req_wdata,
  input  logic [15:0] i_req_user,
  input  logic        i_resp_ready,
  output logic        o_resp_valid,
  output logic [3:0]  o_resp_cmd,
  output logic [63:0] o_resp_rdata,
  output logic [15:0] o_resp_user
);

  localparam logic [3:0] READ_CMD        = 4'b0000;
  localparam logic [3:0] WRITE_CMD       = 4'b0001;
  localparam logic [3:0] READ_BURST_CMD  = 4'b0010;
  localparam logic [3:0] WRITE_BURST_CMD = 4'b0011;
  localparam logic [3:0] PREFETCH_CMD    = 4'b0100;
  localparam logic [3:0] WRITE_RESP_CMD  = 4'b0101;
  localparam logic [3:0] READ_LAST_CMD   = 4'b0110;
  localparam logic [3:0] WRITE_LAST_CMD  = 4'b0111;
  localparam logic [3:0] PROBE_CMD       = 4'b1000;

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int BW    = $clog2(BURST_LEN) + 1;

  localparam logic [BW-1:0]         BEAT_ONE  = BW'(1);
  localparam logic [BW-1:0]         BEAT_LAST = BW'(BURST_LEN - 1);
  localparam logic [BW-1:0]         BEAT_MAX  = BW'(BURST_LEN);
  localparam logic [DEPTH_LOG2-1:0] BLK_MASK  = DEPTH_LOG2'(BURST_LEN - 1);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_RESP     = 2'd1,
    S_RD_BURST = 2'd2,
    S_WR_BURST = 2'd3
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [63:0]           r_mem [0:DEPTH-1];
  logic [BW-1:0]         r_beat;
  logic [BW-1:0]         w_beat_nxt;
  logic [BW-1:0]         w_beat_inc;
  logic [DEPTH_LOG2-1:0] r_burst_base;
  logic [DEPTH_LOG2-1:0] w_burst_base_nxt;
  logic [DEPTH_LOG2-1:0] w_idx;
  logic [DEPTH_LOG2-1:0] w_burst_idx;
  logic                  r_resp_valid;
  logic [3:0]            r_resp_cmd;
  logic [63:0]           r_resp_rdata;
  logic [15:0]           r_resp_user;
  logic                  w_resp_valid_nxt;
  logic [3:0]            w_resp_cmd_nxt;
  logic [63:0]           w_resp_rdata_nxt;
  logic [15:0]           w_resp_user_nxt;
  logic                  w_req_fire;
  logic                  w_resp_fire;
  logic                  w_mem_we;
  logic                  w_unused;

  // Size and the address bits outside the word index carry no meaning here.
  assign w_unused = ^{i_req_size, i_req_addr[31:DEPTH_LOG2+3], i_req_addr[2:0]};

  assign w_idx       = i_req_addr[DEPTH_LOG2+2:3];
  assign o_req_ready = (r_state == S_IDLE) || (r_state == S_WR_BURST);
  assign w_req_fire  = i_req_valid && o_req_ready;
  assign w_resp_fire = r_resp_valid && i_resp_ready;
  assign w_beat_inc  = r_beat + BEAT_ONE;

  // Word for the next burst beat: critical word first, wrapping in the aligned block.
  assign w_burst_idx = (r_burst_base & ~BLK_MASK) |
                       ((r_burst_base + DEPTH_LOG2'(w_beat_inc)) & BLK_MASK);

  assign o_resp_valid = r_resp_valid;
  assign o_resp_cmd   = r_resp_cmd;
  assign o_resp_rdata = r_resp_rdata;
  assign o_resp_user  = r_resp_user;

  // State register
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_req_fire) begin
          case (i_req_cmd)
            READ_CMD, WRITE_CMD, WRITE_LAST_CMD, PROBE_CMD: w_state_nxt = S_RESP;
            READ_BURST_CMD:                                 w_state_nxt = S_RD_BURST;
            WRITE_BURST_CMD:                                w_state_nxt = S_WR_BURST;
            default:                                        w_state_nxt = S_IDLE;
          endcase
        end
      end
      S_RESP: begin
        if (w_resp_fire) w_state_nxt = S_IDLE;
      end
      S_RD_BURST: begin
        if (w_resp_fire && (r_beat == BEAT_LAST)) w_state_nxt = S_IDLE;
      end
      S_WR_BURST: begin
        if (w_req_fire && (i_req_cmd == WRITE_LAST_CMD)) w_state_nxt = S_RESP;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Output / datapath control
  always_comb begin
    w_resp_valid_nxt = r_resp_valid && !w_resp_fire;
    w_resp_cmd_nxt   = r_resp_cmd;
    w_resp_rdata_nxt = r_resp_rdata;
    w_resp_user_nxt  = r_resp_user;
    w_beat_nxt       = r_beat;
    w_burst_base_nxt = r_burst_base;
    w_mem_we         = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_req_fire) begin
          case (i_req_cmd)
            READ_CMD: begin
              w_resp_valid_nxt = 1'b1;
              w_resp_cmd_nxt   = READ_LAST_CMD;
              w_resp_rdata_nxt = r_mem[w_idx];
              w_resp_user_nxt  = i_req_user;
            end
            READ_BURST_CMD: begin
              // Beat 0 is the requested word itself.
              w_resp_valid_nxt = 1'b1;
              w_resp_cmd_nxt   = (BEAT_LAST == '0) ? READ_LAST_CMD : READ_CMD;
              w_resp_rdata_nxt = r_mem[w_idx];
              w_resp_user_nxt  = i_req_user;
              w_burst_base_nxt = w_idx;
              w_beat_nxt       = '0;
            end
            WRITE_CMD, WRITE_LAST_CMD: begin
              w_mem_we         = 1'b1;
              w_resp_valid_nxt = 1'b1;
              w_resp_cmd_nxt   = WRITE_RESP_CMD;
              w_resp_rdata_nxt = '0;
              w_resp_user_nxt  = i_req_user;
            end
            WRITE_BURST_CMD: begin
              w_mem_we   = 1'b1;
              w_beat_nxt = BEAT_ONE;
            end
            PROBE_CMD: begin
              w_resp_valid_nxt = 1'b1;
              w_resp_cmd_nxt   = PROBE_CMD;
              w_resp_rdata_nxt = '0;
              w_resp_user_nxt  = i_req_user;
            end
            default: w_mem_we = 1'b0;
          endcase
        end
      end
      S_RD_BURST: begin
        if (w_resp_fire) begin
          if (r_beat != BEAT_LAST) begin
            w_resp_valid_nxt = 1'b1;
            w_resp_cmd_nxt   = (w_beat_inc == BEAT_LAST) ? READ_LAST_CMD : READ_CMD;
            w_resp_rdata_nxt = r_mem[w_burst_idx];
            w_beat_nxt       = w_beat_inc;
          end else begin
            w_beat_nxt = '0;
          end
        end
      end
      S_WR_BURST: begin
        if (w_req_fire) begin
          if (i_req_cmd == WRITE_BURST_CMD) begin
            // Beats beyond BURST_LEN are dropped; the FSM just waits for WRITE_LAST.
            if (r_beat != BEAT_MAX) begin
              w_mem_we   = 1'b1;
              w_beat_nxt = w_beat_inc;
            end
          end else if (i_req_cmd == WRITE_LAST_CMD) begin
            w_mem_we         = 1'b1;
            w_beat_nxt       = '0;
            w_resp_valid_nxt = 1'b1;
            w_resp_cmd_nxt   = WRITE_RESP_CMD;
            w_resp_rdata_nxt = '0;
            w_resp_user_nxt  = i_req_user;
          end
        end
      end
      default: w_beat_nxt = r_beat;
    endcase
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_resp_valid <= 1'b0;
      r_resp_cmd   <= '0;
      r_resp_rdata <= '0;
      r_resp_user  <= '0;
      r_beat       <= '0;
      r_burst_base <= '0;
    end else begin
      r_resp_valid <= w_resp_valid_nxt;
      r_resp_cmd   <= w_resp_cmd_nxt;
      r_resp_rdata <= w_resp_rdata_nxt;
      r_resp_user  <= w_resp_user_nxt;
      r_beat       <= w_beat_nxt;
      r_burst_base <= w_burst_base_nxt;
    end
  end

  // Memory contents are deliberately not reset.
  always_ff @(posedge i_clock) begin
    if (w_mem_we && !i_reset) begin
      for (int b = 0; b < 8; b++) begin
        if (i_req_wmask[b]) r_mem[w_idx][8*b +: 8] <= i_req_wdata[8*b +: 8];
      end
    end
  end

endmodule
